// File: rtl/cell_score_filter_nbuf.sv
// cell_score_filter_nbuf: thresholds PE scores, queues hit masks, serialises hits onto N rotating result buffers.
// Optional CSF_HIT_COUNT_EN: terminator carries the per-query accepted hit count instead of the block index.
module cell_score_filter_nbuf #(
    parameter int NUM_PES    = 64,
    parameter int WIDTH      = 10,
    parameter int NUM_BUFS   = 2,
    parameter int FIFO_DEPTH = 16,
    localparam int PE_IDX_W  = $clog2(NUM_PES),
    localparam int BUF_W     = $clog2(NUM_BUFS),
    localparam int RES_W     = 1 + 16 + 25 + PE_IDX_W
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        stall_out,
    input  logic [24:0]                 ref_block_cnt_in,
    input  logic [15:0]                 query_id_in,
    input  logic [31:0]                 cell_score_threshold_in,
    input  logic                        tracking_info_valid_in,
    input  logic [NUM_PES*WIDTH-1:0]    V_out_in,
    input  logic [NUM_PES-1:0]          V_out_valid_in,
    input  logic                        end_of_query_in,
    output logic [NUM_BUFS*RES_W-1:0]   result_data_out,
    output logic [NUM_BUFS-1:0]         result_valid_out,
    input  logic [NUM_BUFS-1:0]         result_rdy_in
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 1 + 16 + 25 + NUM_PES;

    typedef enum logic [1:0] {IDLE, LOAD, EMIT, TERM} state_t;

    logic [EW-1:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]       r_wr, r_rd;
    logic [AW:0]         r_cnt;
    logic                r_stall;
    state_t              r_state;
    logic [NUM_PES-1:0]  r_mask;
    logic                r_eoq;
    logic [15:0]         r_qid;
    logic [24:0]         r_blk;
    logic [RES_W-1:0]    r_data;
    logic                r_valid;
    logic [BUF_W-1:0]    r_sel;
    logic [NUM_PES-1:0]  w_hit;
    logic [PE_IDX_W-1:0] w_k;
    logic                w_push, w_pop, w_acc, w_free;
    logic [AW:0]         w_cnt_nxt;
    logic [24:0]         w_term_blk;

    always_comb begin
        w_hit = '0;
        for (int i = 0; i < NUM_PES; i++)
            w_hit[i] = V_out_valid_in[i] &
                       ($signed(V_out_in[i*WIDTH +: WIDTH]) >= $signed(cell_score_threshold_in));
    end

    // Lowest-PE-first: the last assignment in a descending scan wins.
    always_comb begin
        w_k = '0;
        for (int i = NUM_PES - 1; i >= 0; i--)
            if (r_mask[i]) w_k = PE_IDX_W'(i);
    end

    assign w_push    = tracking_info_valid_in & ~r_stall & (|w_hit | end_of_query_in);
    assign w_pop     = r_state == LOAD;
    assign w_cnt_nxt = r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    assign w_acc     = r_valid & result_rdy_in[r_sel];
    assign w_free    = ~r_valid | w_acc;

`ifdef CSF_HIT_COUNT_EN
    logic [24:0] r_hits, w_hits;
    assign w_hits     = (r_state == EMIT && w_acc && r_hits != '1) ? r_hits + 25'd1 : r_hits;
    assign w_term_blk = w_hits;
    always_ff @(posedge clk or posedge rst)
        if (rst) r_hits <= '0;
        else     r_hits <= (r_state == TERM && w_acc) ? '0 : w_hits;
`else
    assign w_term_blk = r_blk;
`endif

    always_ff @(posedge clk)
        if (w_push) r_mem[r_wr] <= {end_of_query_in, query_id_in, ref_block_cnt_in, w_hit};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_cnt   <= '0;
            r_stall <= 1'b0;
            r_state <= IDLE;
            r_mask  <= '0;
            r_eoq   <= 1'b0;
            r_qid   <= '0;
            r_blk   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_sel   <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            r_cnt   <= w_cnt_nxt;
            r_stall <= w_cnt_nxt >= (AW+1)'(FIFO_DEPTH - 2);
            case (r_state)
                IDLE: if (r_cnt != '0) r_state <= LOAD;
                LOAD: begin
                    {r_eoq, r_qid, r_blk, r_mask} <= r_mem[r_rd];
                    r_state <= EMIT;
                end
                // A free output slot is refilled on the same edge it drains, giving one result per cycle.
                EMIT: if (w_free) begin
                    if (|r_mask) begin
                        r_data      <= {1'b0, r_qid, r_blk, w_k};
                        r_valid     <= 1'b1;
                        r_mask[w_k] <= 1'b0;
                    end else if (r_eoq) begin
                        r_data  <= {1'b1, r_qid, w_term_blk, {PE_IDX_W{1'b0}}};
                        r_valid <= 1'b1;
                        r_state <= TERM;
                    end else begin
                        r_valid <= 1'b0;
                        r_state <= (r_cnt != '0) ? LOAD : IDLE;
                    end
                end
                TERM: if (w_acc) begin
                    r_valid <= 1'b0;
                    r_sel   <= (r_sel == BUF_W'(NUM_BUFS - 1)) ? '0 : r_sel + 1'b1;
                    r_state <= (r_cnt != '0) ? LOAD : IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        w_push |-> r_cnt < (AW+1)'(FIFO_DEPTH));

    assign stall_out        = r_stall;
    assign result_valid_out = NUM_BUFS'(r_valid) << r_sel;
    assign result_data_out  = {NUM_BUFS{r_data}};
endmodule

// File: tb/tb_cell_score_filter_nbuf.sv
// tb_cell_score_filter_nbuf: directed and randomised columns against a queue-based result model.
// Build with CSF_HIT_COUNT_EN defined to expect hit counts in terminators.
module tb_cell_score_filter_nbuf;
    localparam int NP = 64, W = 10, NB = 3, FD = 16, PW = 6, RW = 1 + 16 + 25 + PW;

    logic              clk = 1'b0, rst = 1'b1, stall, tv, eoq;
    logic [24:0]       blk;
    logic [15:0]       qid;
    logic [31:0]       thr;
    logic [NP*W-1:0]   v;
    logic [NP-1:0]     vv;
    logic [NB*RW-1:0]  data;
    logic [NB-1:0]     valid, rdy;

    cell_score_filter_nbuf #(.NUM_PES(NP), .WIDTH(W), .NUM_BUFS(NB), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .stall_out(stall), .ref_block_cnt_in(blk), .query_id_in(qid),
        .cell_score_threshold_in(thr), .tracking_info_valid_in(tv), .V_out_in(v),
        .V_out_valid_in(vv), .end_of_query_in(eoq), .result_data_out(data),
        .result_valid_out(valid), .result_rdy_in(rdy));

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {int b; logic [63:0] d;} exp_t;
    exp_t q[$];
    exp_t e;
    int msel = 0, mhits = 0, cap_cnt = 0, valid_cycles = 0, hold_b = 0;
    bit stall_seen = 0, hold = 0;
    logic [63:0] hold_d;

    function automatic void model_capture();
        int t, s;
        bit any;
        t = $signed(thr);
        any = eoq;
        for (int i = 0; i < NP; i++) begin
            s = $signed(v[i*W +: W]);
            if (vv[i] && s >= t) begin
                q.push_back('{msel, 64'({1'b0, qid, blk, PW'(i)})});
                mhits++;
                any = 1;
            end
        end
        if (eoq) begin
`ifdef CSF_HIT_COUNT_EN
            q.push_back('{msel, 64'({1'b1, qid, 25'(mhits), {PW{1'b0}}})});
`else
            q.push_back('{msel, 64'({1'b1, qid, blk, {PW{1'b0}}})});
`endif
            msel = (msel + 1) % NB;
            mhits = 0;
        end
        if (any) cap_cnt++;
    endfunction

    always @(negedge clk) begin
        if (rst) hold = 0;
        else begin
            if (tv && !stall) model_capture();
            if (stall) stall_seen = 1;
            if (|valid) valid_cycles++;
            check("onehot0", 64'($countones(valid) <= 1), 1);
            if (hold) begin
                check("hold_valid", valid[hold_b], 1);
                check("hold_data", data[hold_b*RW +: RW], hold_d);
            end
            hold = 0;
            for (int b = 0; b < NB; b++)
                if (valid[b]) begin
                    if (rdy[b]) begin
                        check("result_expected", q.size() != 0, 1);
                        if (q.size() != 0) begin
                            e = q.pop_front();
                            check("buf", b, e.b);
                            check("data", data[b*RW +: RW], e.d);
                        end
                    end else begin
                        hold = 1;
                        hold_b = b;
                        hold_d = data[b*RW +: RW];
                    end
                end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        tv = 0; eoq = 0; vv = '0; v = '0;
    endtask

    task automatic set_pe(int i, int s, logic val);
        v[i*W +: W] = W'(s);
        vv[i] = val;
    endtask

    task automatic put_col(logic [15:0] q_, logic [24:0] b_, logic e_);
        tv = 1; qid = q_; blk = b_; eoq = e_;
    endtask

    task automatic drain(int budget);
        rdy = '1;
        idle_inputs();
        for (int n = 0; n < budget && q.size() != 0; n++) tick();
        check("drain_empty", q.size(), 0);
        repeat (6) tick();
        check("drain_idle_valid", valid, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        int lat;
        idle_inputs();
        qid = 0; blk = 0; thr = 0; rdy = '1;
        repeat (3) @(posedge clk);
        #1 rst = 0;

        for (int n = 0; n < 20; n++) begin
            tick();
            check("reset_valid", valid, 0);
            check("reset_stall", stall, 0);
            check("reset_data", |data, 0);
        end

        thr = 8;
        set_pe(3, 8, 1); set_pe(10, -1, 1); set_pe(40, 20, 1);
        put_col(16'h0005, 25'd7, 0);
        tick();
        idle_inputs();
        lat = 0;
        while (valid == '0 && lat < 10) begin
            lat++;
            tick();
        end
        check("latency", lat, 3);
        check("first_buf", valid, 3'b001);
        check("first_pe", data[PW-1:0], 3);
        tick();
        check("b2b_valid", valid, 3'b001);
        check("b2b_pe", data[PW-1:0], 40);
        tick();
        check("after_hits_valid", valid, 0);
        drain(50);

        for (int k = 0; k < 4; k++) begin
            thr = 8;
            set_pe(3, 8, 1); set_pe(10, -1, 1); set_pe(40, 20, 1);
            put_col(16'h0005 + 16'(k), 25'd7 + 25'(k), 1);
            tick();
            idle_inputs();
            repeat (12) tick();
        end
        drain(50);

        rdy = '0; stall_seen = 0; cap_cnt = 0; thr = 8;
        for (int n = 0; n < 30; n++) begin
            idle_inputs();
            set_pe(n % NP, 100, 1);
            put_col(16'h0100, 25'(n), 0);
            tick();
        end
        idle_inputs();
        check("stall_rose", stall_seen, 1);
        check("no_overflow", cap_cnt <= FD, 1);
        drain(400);
        check("stall_clear", stall, 0);

        thr = 8; valid_cycles = 0;
        set_pe(5, 50, 0);
        put_col(16'h0200, 25'd1, 0);
        tick();
        idle_inputs();
        set_pe(6, 7, 1);
        put_col(16'h0200, 25'd2, 0);
        tick();
        idle_inputs();
        repeat (8) tick();
        check("no_result", valid_cycles, 0);

        thr = 32'hFFFF_FFFB;
        set_pe(1, -5, 1); set_pe(2, -6, 1); set_pe(9, 0, 1);
        put_col(16'h0300, 25'd11, 0);
        tick();
        idle_inputs();
        set_pe(20, -5, 1); set_pe(33, 511, 1);
        put_col(16'h0300, 25'd12, 1);
        tick();
        drain(100);

        for (int n = 0; n < 400; n++) begin
            idle_inputs();
            rdy = NB'($urandom) | NB'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < NP; i++) v[i*W +: W] = W'($urandom);
                vv = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
                thr = 32'($urandom_range(0, 1100)) - 32'd550;
                put_col(16'($urandom), 25'($urandom), $urandom_range(0, 7) == 0);
            end
            tick();
        end
        drain(4000);

        thr = 0;
        for (int i = 0; i < 20; i++) set_pe(i * 3, 100, 1);
        put_col(16'h0400, 25'd3, 1);
        tick();
        idle_inputs();
        repeat (6) tick();
        rst = 1;
        #1;
        check("rst_valid", valid, 0);
        check("rst_stall", stall, 0);
        q.delete();
        msel = 0; mhits = 0;
        tick();
        tick();
        rst = 0;
        set_pe(7, 60, 1); set_pe(8, 60, 1);
        put_col(16'h0500, 25'd9, 1);
        tick();
        idle_inputs();
        drain(100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
